// File: rtl/pbkdf2_digest_collector.sv
// Deserializes the pbkdf2_chunk 1-bit result stream into a digest buffer
// and replays it to the host as num_words_p words under valid/yumi.
module pbkdf2_digest_collector #(
    parameter int word_width_p = 32,
    parameter int num_words_p  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    bit_v_i,
    input  logic                    bit_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [word_width_p-1:0] data_o,
    output logic                    last_o,
    input  logic                    yumi_i
);

    localparam int N  = word_width_p * num_words_p;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (num_words_p > 1) ? $clog2(num_words_p) : 1;

    typedef enum logic {
        FILL,
        DRAIN
    } state_e;

    state_e            state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [N-1:0]      buffer;
    logic              bit_acc;
    logic              yumi_acc;
    logic              is_last;

    logic [word_width_p-1:0] words [num_words_p];

    assign bit_acc  = bit_v_i & ready_o;
    assign yumi_acc = yumi_i & v_o;
    assign is_last  = (idx == IW'(num_words_p - 1));

    // Word 0 holds the earliest bits, so it sits at the top of the buffer.
    for (genvar g = 0; g < num_words_p; g++) begin : g_words
        assign words[g] = buffer[N-1-g*word_width_p -: word_width_p];
    end

    assign data_o = v_o ? words[idx] : '0;
    assign last_o = v_o & is_last;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            state   <= FILL;
            cnt     <= '0;
            idx     <= '0;
            buffer  <= '0;
            ready_o <= 1'b1;
            v_o     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (bit_acc) begin
                        buffer <= {buffer[N-2:0], bit_i};
                        if (cnt == CW'(N - 1)) begin
                            state   <= DRAIN;
                            cnt     <= '0;
                            idx     <= '0;
                            ready_o <= 1'b0;
                            v_o     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Buffer is left intact here; the next fill overwrites it.
                    if (yumi_acc) begin
                        if (is_last) begin
                            state   <= FILL;
                            idx     <= '0;
                            ready_o <= 1'b1;
                            v_o     <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbkdf2_digest_collector.sv
// Directed bench for pbkdf2_digest_collector: fill/drain, pacing,
// clear in both phases and clear-vs-bit precedence.
module tb_pbkdf2_digest_collector;

    logic        clk;
    logic        reset;
    logic        clear_i;
    logic        bit_v_i;
    logic        bit_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        last_o;
    logic        yumi_i;

    int total;
    int bad;

    logic [255:0] pat2;
    logic [255:0] pat3;
    logic [255:0] ones;

    pbkdf2_digest_collector #(
        .word_width_p(32),
        .num_words_p (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear_i),
        .bit_v_i(bit_v_i),
        .bit_i  (bit_i),
        .ready_o(ready_o),
        .v_o    (v_o),
        .data_o (data_o),
        .last_o (last_o),
        .yumi_i (yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams the first n bits of p MSB first; the collector must stay in FILL.
    task automatic stream(input logic [255:0] p, input int n, input string tag);
        bit_v_i = 1'b1;
        for (int k = 0; k < n; k++) begin
            bit_i = p[255-k];
            total++;
            if (ready_o !== 1'b1 || v_o !== 1'b0) begin
                bad++;
                $display("FAIL %s fill bit %0d: ready=%b v=%b want ready=1 v=0",
                         tag, k, ready_o, v_o);
            end
            tick();
        end
        bit_v_i = 1'b0;
        bit_i   = 1'b0;
    endtask

    task automatic drain_all(input logic [255:0] p, input string tag);
        yumi_i = 1'b1;
        for (int w = 0; w < 8; w++) begin
            total++;
            if (v_o !== 1'b1 || ready_o !== 1'b0 ||
                data_o !== p[255-32*w -: 32] || last_o !== (w == 7)) begin
                bad++;
                $display("FAIL %s word %0d: v=%b rdy=%b data=%h last=%b want data=%h",
                         tag, w, v_o, ready_o, data_o, last_o, p[255-32*w -: 32]);
            end
            tick();
        end
        yumi_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || data_o !== 32'h0) begin
            bad++;
            $display("FAIL %s after drain: ready=%b v=%b data=%h want 1 0 0",
                     tag, ready_o, v_o, data_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (ready_o !== 1'b1 || v_o !== 1'b0 ||
                data_o !== 32'h0 || last_o !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc %0d: ready=%b v=%b data=%h last=%b want 1 0 0 0",
                         c, ready_o, v_o, data_o, last_o);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_stream_full_yumi();
        logic [31:0] exp;
        stream(pat2, 256, "t2");
        yumi_i = 1'b1;
        for (int w = 0; w < 8; w++) begin
            exp = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            total++;
            if (v_o !== 1'b1 || data_o !== exp || last_o !== (w == 7) ||
                ready_o !== 1'b0) begin
                bad++;
                $display("FAIL t2 word %0d: v=%b data=%h last=%b rdy=%b want data=%h",
                         w, v_o, data_o, last_o, ready_o, exp);
            end
            tick();
        end
        yumi_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || last_o !== 1'b0) begin
            bad++;
            $display("FAIL t2 after drain: ready=%b v=%b last=%b want 1 0 0",
                     ready_o, v_o, last_o);
        end
    endtask

    task automatic test_paced_yumi();
        int w;
        int c;
        w = 0;
        c = 0;
        stream(pat2, 256, "t3");
        bit_i = 1'b1;
        while (w < 8 && c < 40) begin
            yumi_i  = (c % 3 == 2);
            bit_v_i = c[0];
            total++;
            if (v_o !== 1'b1 || ready_o !== 1'b0 ||
                data_o !== pat2[255-32*w -: 32] || last_o !== (w == 7)) begin
                bad++;
                $display("FAIL t3 cyc %0d word %0d: v=%b rdy=%b data=%h last=%b want %h",
                         c, w, v_o, ready_o, data_o, last_o, pat2[255-32*w -: 32]);
            end
            if (yumi_i) w++;
            tick();
            c++;
        end
        yumi_i  = 1'b0;
        bit_v_i = 1'b0;
        bit_i   = 1'b0;
        total++;
        if (w != 8 || ready_o !== 1'b1 || v_o !== 1'b0) begin
            bad++;
            $display("FAIL t3 end: words=%0d ready=%b v=%b want 8 1 0", w, ready_o, v_o);
        end
    endtask

    task automatic test_clear_in_drain();
        stream(pat2, 256, "t5");
        yumi_i = 1'b1;
        for (int w = 0; w < 4; w++) begin
            total++;
            if (v_o !== 1'b1 || data_o !== pat2[255-32*w -: 32]) begin
                bad++;
                $display("FAIL t5 word %0d: v=%b data=%h want %h",
                         w, v_o, data_o, pat2[255-32*w -: 32]);
            end
            tick();
        end
        yumi_i  = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        total++;
        if (v_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 32'h0 || last_o !== 1'b0) begin
            bad++;
            $display("FAIL t5 clear: v=%b ready=%b data=%h last=%b want 0 1 0 0",
                     v_o, ready_o, data_o, last_o);
        end
        stream(pat3, 256, "t5b");
        drain_all(pat3, "t5b");
    endtask

    task automatic test_clear_in_fill();
        stream(pat2, 100, "t4");
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        total++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            bad++;
            $display("FAIL t4 clear: ready=%b v=%b want 1 0", ready_o, v_o);
        end
        stream(ones, 256, "t4");
        drain_all(ones, "t4");
    endtask

    task automatic test_clear_vs_last_bit();
        stream(pat2, 255, "t6");
        bit_v_i = 1'b1;
        bit_i   = pat2[0];
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        bit_v_i = 1'b0;
        total++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            bad++;
            $display("FAIL t6 clear wins: v=%b ready=%b want 0 1", v_o, ready_o);
        end
        stream(pat3, 256, "t6b");
        total++;
        if (v_o !== 1'b1) begin
            bad++;
            $display("FAIL t6 refill: v=%b want 1", v_o);
        end
        drain_all(pat3, "t6b");
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        clear_i = 1'b0;
        bit_v_i = 1'b0;
        bit_i   = 1'b0;
        yumi_i  = 1'b0;
        ones    = '1;
        for (int i = 0; i < 32; i++) pat2[255-8*i -: 8] = 8'(i);
        for (int w = 0; w < 8; w++) pat3[255-32*w -: 32] = 32'hDEAD0000 + 32'(w);

        test_reset();
        test_stream_full_yumi();
        test_paced_yumi();
        test_clear_in_drain();
        test_clear_in_fill();
        test_clear_vs_last_bit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
